// File: rtl/uart_pkg.sv
// Shared UART definitions used by the TX and RX datapaths.
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 434;
    localparam int unsigned UART_DATA_BITS            = 8;

endpackage

// File: rtl/uart_tx_controller_if.sv
// Core-side handshake, shift-register strobes and line outputs of the TX controller.
interface uart_tx_controller_if;

    logic valid_i;
    logic ready_o;
    logic load_byte_o;
    logic shift_o;
    logic serial_i;
    logic tx_o;
    logic busy_o;
    logic done_o;

    // Controller side.
    modport slave (
        input  valid_i,
        input  serial_i,
        output ready_o,
        output load_byte_o,
        output shift_o,
        output tx_o,
        output busy_o,
        output done_o
    );

    // Core / shift-register side.
    modport master (
        output valid_i,
        output serial_i,
        input  ready_o,
        input  load_byte_o,
        input  shift_o,
        input  tx_o,
        input  busy_o,
        input  done_o
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..ClksPerBit-1, flags the last cycle with tick.
module uart_baud_gen #(
    parameter int unsigned ClksPerBit = 434
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = $clog2(ClksPerBit);
    localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    assign tick = (cnt_q == CntLast);

    // Clear wins over counting; wrap to zero after the last cycle of a bit.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_controller.sv
// UART transmit sequencer: frames start, 8 data bits (LSB first) and stop bit.
module uart_tx_controller
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    uart_tx_controller_if.slave   bus
);

    localparam int unsigned IdxW = $clog2(UART_DATA_BITS);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(UART_DATA_BITS - 1);

    tx_state_e       state_q, state_d;
    logic [IdxW-1:0] bit_idx_q, bit_idx_d;
    logic            done_q, done_d;
    logic            tick;
    logic            shift;
    logic            tx;
    logic            cnt_clear;

    // Counter restarts on every state change so each state lasts whole bit periods.
    assign cnt_clear = (state_q == TX_IDLE) || (state_d != state_q);

    uart_baud_gen #(
        .ClksPerBit (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear  (cnt_clear),
        .tick   (tick)
    );

    // Next-state, bit counter and shift strobe.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift     = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                if (bus.valid_i) begin
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (tick) begin
                    shift     = 1'b1;
                    bit_idx_d = '0;
                    state_d   = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (bit_idx_q == IdxLast) begin
                        state_d = TX_STOP;
                    end else begin
                        shift     = 1'b1;
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    state_d = TX_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    // Line level depends only on state and the shift register output.
    always_comb begin
        tx = 1'b1;
        unique case (state_q)
            TX_START: tx = 1'b0;
            TX_DATA:  tx = bus.serial_i;
            default:  tx = 1'b1;
        endcase
    end

    // State, bit counter and registered done pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= TX_IDLE;
            bit_idx_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            done_q    <= done_d;
        end
    end

    assign bus.ready_o     = (state_q == TX_IDLE);
    assign bus.load_byte_o = bus.valid_i && (state_q == TX_IDLE);
    assign bus.shift_o     = shift;
    assign bus.tx_o        = tx;
    assign bus.busy_o      = (state_q != TX_IDLE);
    assign bus.done_o      = done_q;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Randomized self-checking bench for uart_tx_controller (C=4 and C=2 instances).
module tb_uart_tx_controller;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic       drv_valid [2];
    logic [7:0] drv_data  [2];
    logic [8:0] sr4 = '1;
    logic [8:0] sr2 = '1;

    uart_tx_controller_if ifc4 ();
    uart_tx_controller_if ifc2 ();

    uart_tx_controller #(.CLKS_PER_BIT(4)) dut4 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (ifc4.slave)
    );

    uart_tx_controller #(.CLKS_PER_BIT(2)) dut2 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (ifc2.slave)
    );

    assign ifc4.valid_i  = drv_valid[0];
    assign ifc2.valid_i  = drv_valid[1];
    assign ifc4.serial_i = sr4[0];
    assign ifc2.serial_i = sr2[0];

    always #5 clk = ~clk;

    // Behavioural 9-bit shift registers: bit 0 holds the start bit after load.
    always @(posedge clk) begin
        if (ifc4.load_byte_o)  sr4 <= {drv_data[0], 1'b0};
        else if (ifc4.shift_o) sr4 <= {1'b1, sr4[8:1]};
        if (ifc2.load_byte_o)  sr2 <= {drv_data[1], 1'b0};
        else if (ifc2.shift_o) sr2 <= {1'b1, sr2[8:1]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        if (cyc > 20000) begin
            $display("FAIL watchdog: cycle budget exceeded");
            $fatal(1, "watchdog");
        end
    end

    // Reference model: frame timing derived from the handshake cycle t.
    bit         m_act   [2] = '{0, 0};
    int         m_ths   [2] = '{0, 0};
    logic [7:0] m_byte  [2];
    int         m_shcnt [2] = '{0, 0};
    int         hs_cyc  [2] = '{0, 0};

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            int   c, n, bp;
            logic o_rdy, o_ld, o_sh, o_tx, o_bsy, o_dn;
            logic e_idle, e_tx, e_sh, e_dn, e_ld;
            c = (i == 0) ? 4 : 2;
            if (i == 0) begin
                o_rdy = ifc4.ready_o; o_ld = ifc4.load_byte_o; o_sh = ifc4.shift_o;
                o_tx  = ifc4.tx_o;    o_bsy = ifc4.busy_o;     o_dn = ifc4.done_o;
            end else begin
                o_rdy = ifc2.ready_o; o_ld = ifc2.load_byte_o; o_sh = ifc2.shift_o;
                o_tx  = ifc2.tx_o;    o_bsy = ifc2.busy_o;     o_dn = ifc2.done_o;
            end
            if (!rst_n) m_act[i] = 1'b0;
            n      = cyc - m_ths[i];
            e_idle = !m_act[i] || (n > 10 * c);
            e_tx   = 1'b1;
            e_sh   = 1'b0;
            if (!e_idle) begin
                bp = (n - 1) / c;
                if (bp == 0)      e_tx = 1'b0;
                else if (bp <= 8) e_tx = m_byte[i][bp-1];
                e_sh = (n % c == 0) && (n / c >= 1) && (n / c <= 8);
            end
            e_dn = m_act[i] && (n == 10 * c + 1);
            e_ld = drv_valid[i] && e_idle;
            if (o_sh === 1'b1) m_shcnt[i]++;
            check($sformatf("ready%0d", i), o_rdy, e_idle);
            check($sformatf("busy%0d", i), o_bsy, !e_idle);
            check($sformatf("tx%0d", i), o_tx, e_tx);
            check($sformatf("shift%0d", i), o_sh, e_sh);
            check($sformatf("done%0d", i), o_dn, e_dn);
            check($sformatf("load%0d", i), o_ld, e_ld);
            if (e_dn) check($sformatf("shift_count%0d", i), m_shcnt[i], 8);
            if (rst_n && e_ld) begin
                m_act[i]   = 1'b1;
                m_ths[i]   = cyc;
                m_byte[i]  = drv_data[i];
                m_shcnt[i] = 0;
                hs_cyc[i]  = cyc;
            end
        end
    end

    // Present a byte and wait for its handshake; optionally keep valid high afterwards.
    task automatic send(input int idx, input logic [7:0] b, input bit keep, output int hs);
        bit got = 1'b0;
        drv_valid[idx] = 1'b1;
        drv_data[idx]  = b;
        hs = -1;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if ((idx == 0 ? ifc4.load_byte_o : ifc2.load_byte_o) === 1'b1) begin
                got = 1'b1;
                hs  = cyc;
            end
        end
        if (!got) check("handshake_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!keep) drv_valid[idx] = 1'b0;
    endtask

    initial begin
        int h1, h2, k;
        rst_n = 1'b0;
        drv_valid[0] = 1'b0; drv_valid[1] = 1'b0;
        drv_data[0]  = '0;   drv_data[1]  = '0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single frame.
        send(0, 8'hA5, 1'b0, h1);
        repeat (41) @(posedge clk);
        #1;

        // Back-to-back with valid held high.
        send(0, 8'h00, 1'b1, h1);
        send(0, 8'hFF, 1'b0, h2);
        check("b2b_gap", h2 - h1, 41);
        repeat (41) @(posedge clk);
        #1;

        // Valid pulse in cycle t+10 must be ignored.
        send(0, 8'h5A, 1'b0, h1);
        repeat (9) @(posedge clk);
        #1;
        drv_valid[0] = 1'b1;
        drv_data[0]  = 8'($urandom);
        @(posedge clk);
        #1;
        drv_valid[0] = 1'b0;
        repeat (31) @(posedge clk);
        #1;

        // Asynchronous reset during DATA bit 3.
        send(0, 8'hC3, 1'b0, h1);
        repeat (17) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", ifc4.tx_o, 1'b1);
        check("async_rst_ready", ifc4.ready_o, 1'b1);
        check("async_rst_busy", ifc4.busy_o, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(0, 8'h3C, 1'b0, h1);
        repeat (41) @(posedge clk);
        #1;

        // Random frames with random gaps and ignored valid noise.
        for (int f = 0; f < 8; f++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            send(0, 8'($urandom), 1'b0, h1);
            k = $urandom_range(2, 38);
            repeat (k - 1) @(posedge clk);
            #1;
            drv_valid[0] = $urandom_range(0, 1) == 1;
            drv_data[0]  = 8'($urandom);
            @(posedge clk);
            #1;
            drv_valid[0] = 1'b0;
            repeat (40 - k) @(posedge clk);
            #1;
        end

        // Short bit period instance.
        send(1, 8'h81, 1'b0, h1);
        repeat (21) @(posedge clk);
        #1;
        send(1, 8'($urandom), 1'b1, h1);
        send(1, 8'($urandom), 1'b0, h2);
        check("b2b_gap_c2", h2 - h1, 21);
        repeat (25) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
